scr1_pipe_mprf_sb: RTL
======================

# scr1_pipe_mprf_sb

Parametrised multi-port register file with write-through bypass and a per-register pending-write scoreboard. It replaces the fixed 2-read/1-write MPRF in the pipeline. EXU gets N read ports, and M writeback ports for ALU, LSU and MUL/DIV. Long-latency destinations are marked busy at issue and cleared on writeback, so EXU can detect RAW hazards without a separate tracker.

## Interface
Parameters:
- XLEN, 32, data width
- RVE, 0, 1 gives 16 architectural registers (x0–x15), 0 gives 32
- NUM_RD, 2, read ports (1–4)
- NUM_WR, 1, write ports (1–3); higher index has priority
- AW, derived, address width: 4 if RVE else 5 (not overridable)
- NREGS, derived, 2**AW

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- exu2mprf_rs_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
- mprf2exu_rs_data  out  NUM_RD*XLEN  read data
- mprf2exu_rs_busy  out  NUM_RD  read register has a pending write
- exu2mprf_w_req  in  NUM_WR  write request per port
- exu2mprf_w_clr  in  NUM_WR  this write also clears the scoreboard bit
- exu2mprf_rd_addr  in  NUM_WR*AW  write addresses
- exu2mprf_rd_data  in  NUM_WR*XLEN  write data
- exu2mprf_iss_req  in  1  mark a destination pending
- exu2mprf_iss_addr  in  AW  destination to mark
- mprf2exu_busy_vec  out  NREGS  registered scoreboard; bit 0 is always 0
- mprf2exu_pend_cnt  out  AW+1  registered count of set busy bits

## Operation
- Storage: registers 1..NREGS-1, XLEN bits each. x0 has no storage, reads 0, ignores writes, and is never marked busy.
- Write: at posedge, for each address, the highest-index port with w_req=1 and a matching non-zero address writes its data. Lower-priority writes to the same address in that cycle are dropped.
- Read port i:
  - If rs_addr=0, rs_data=0.
  - Otherwise, if any w_req port targets rs_addr this cycle, rs_data is that write's data (highest index wins). This is the write-through bypass.
  - Otherwise rs_data is the stored value.
- Scoreboard, next-state per register r≠0:
  - set = iss_req & iss_addr==r
  - clr = any port with w_req & w_clr & rd_addr==r
  - busy_next = set | (busy & ~clr)
  - When set and clr coincide, set wins: the new issue supersedes the old writeback.
- rs_busy[i]: busy[rs_addr] & ~clr_this_cycle(rs_addr), or set_this_cycle(rs_addr). Forced to 0 when rs_addr=0. This is the same-cycle view consistent with the data bypass.
- Writes with w_clr=0 update data only; busy is untouched.
- Writes with w_clr=1 to a non-busy register are legal; the bit stays 0.
- Issue to a register that is already busy leaves it busy. No count change; this is not an error.
- pend_cnt equals popcount(busy_vec), kept as a register updated incrementally. Range is 0..NREGS-1, with no wrap.

## Timing
- Reads are combinational from addresses and the same-cycle write inputs. Zero latency.
- Write data becomes visible:
  - cycle N, through the bypass
  - cycle N+1 onward, from storage
- busy_vec and pend_cnt are registered; an issue in cycle N is visible there from N+1.
- Reset (rst=1 at posedge): all storage = 0, busy_vec = 0, pend_cnt = 0.
  - rst overrides any w_req or iss_req in the same cycle.
  - While rst is high, rs_data still reflects the combinational bypass. Storage reads return 0 after the first reset edge.
- Reset mid-operation discards all pending marks. EXU must flush in-flight long-latency operations in the same reset.
- No handshake or backpressure. Every request is accepted in the cycle it is asserted.

## Structure
- Shared package scr1_mprf_pkg holds:
  - AW/NREGS derivation function
  - type_scr1_mprf_v
  - scr1_mprf_sb_t (NREGS-bit scoreboard vector)
- Sub-module scr1_mprf_scoreboard: busy vector, set/clr resolution, pend_cnt counter, plus a per-address combinational busy lookup. The top keeps data storage, write arbitration and the read bypass.
- Simulation-only assertions, excluded from synthesis:
  - no X on w_req address/data when w_req is set
  - pend_cnt == $countones(busy_vec)

## Test plan
- Reset and x0:
  - Stimulus: rst 2 cycles, then read all addresses; write 0xDEADBEEF to x0 with w_clr=1, then iss_req to x0.
  - Response: every read returns 0; after the x0 write, x0 still reads 0; after the x0 issue, busy_vec=0 and pend_cnt=0.
- Bypass:
  - Stimulus: in cycle N, write x5=0x12345678 and read x5 on every port.
  - Response: reads return 0x12345678 in N and in N+1.
- Write priority (NUM_WR=2):
  - Stimulus: port0 writes x7=0x1 and port1 writes x7=0x2 in the same cycle.
  - Response: bypass gives 0x2, and storage holds 0x2 next cycle.
- Scoreboard lifecycle:
  - Issue x3 → busy_vec[3]=1, pend_cnt=1.
  - Read x3 → rs_busy=1.
  - Writeback x3=0xAA with w_clr=1 → rs_busy=0 in that same cycle, data 0xAA; next cycle busy_vec[3]=0, pend_cnt=0.
- Simultaneous set and clear:
  - Stimulus: x9 is busy; in one cycle, issue x9 and write back x9 with w_clr=1.
  - Response: busy_vec[9] stays 1, pend_cnt is unchanged, data is updated.
- Fill and mid-operation reset:
  - Stimulus: issue x1..x31 on consecutive cycles.
  - Response: pend_cnt reaches 31.
  - Stimulus: rst=1 concurrent with w_req to x4.
  - Response: next cycle busy_vec=0, pend_cnt=0, x4 reads 0.

Source files
------------

// File: rtl/scr1_pipe_mprf_sb_pkg.sv
// Shared definitions for the multi-port register file and its pending-write scoreboard.
package scr1_mprf_pkg;

   localparam int unsigned SCR1_MPRF_XLEN     = 32;
   localparam int unsigned SCR1_MPRF_NREGS_MX = 32;

   typedef logic [SCR1_MPRF_XLEN-1:0]     type_scr1_mprf_v;
   typedef logic [SCR1_MPRF_NREGS_MX-1:0] scr1_mprf_sb_t;

   // Address width follows the architectural register count (RV32E has 16).
   function automatic int unsigned scr1_mprf_aw(input int unsigned rve);
      return (rve != 0) ? 4 : 5;
   endfunction

   function automatic int unsigned scr1_mprf_nregs(input int unsigned rve);
      return 1 << scr1_mprf_aw(rve);
   endfunction

endpackage : scr1_mprf_pkg

// File: rtl/scr1_pipe_mprf_sb_if.sv
// EXU <-> MPRF bundle: read ports, writeback ports, issue marking and scoreboard view.
interface scr1_pipe_mprf_sb_if
   import scr1_mprf_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned RVE    = 0,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1
);

   localparam int unsigned AW    = scr1_mprf_aw(RVE);
   localparam int unsigned NREGS = scr1_mprf_nregs(RVE);

   logic [NUM_RD*AW-1:0]   exu2mprf_rs_addr;
   logic [NUM_RD*XLEN-1:0] mprf2exu_rs_data;
   logic [NUM_RD-1:0]      mprf2exu_rs_busy;

   logic [NUM_WR-1:0]      exu2mprf_w_req;
   logic [NUM_WR-1:0]      exu2mprf_w_clr;
   logic [NUM_WR*AW-1:0]   exu2mprf_rd_addr;
   logic [NUM_WR*XLEN-1:0] exu2mprf_rd_data;

   logic                   exu2mprf_iss_req;
   logic [AW-1:0]          exu2mprf_iss_addr;

   logic [NREGS-1:0]       mprf2exu_busy_vec;
   logic [AW:0]            mprf2exu_pend_cnt;

   modport master (
      output exu2mprf_rs_addr, exu2mprf_w_req, exu2mprf_w_clr, exu2mprf_rd_addr,
             exu2mprf_rd_data, exu2mprf_iss_req, exu2mprf_iss_addr,
      input  mprf2exu_rs_data, mprf2exu_rs_busy, mprf2exu_busy_vec, mprf2exu_pend_cnt
   );

   modport slave (
      input  exu2mprf_rs_addr, exu2mprf_w_req, exu2mprf_w_clr, exu2mprf_rd_addr,
             exu2mprf_rd_data, exu2mprf_iss_req, exu2mprf_iss_addr,
      output mprf2exu_rs_data, mprf2exu_rs_busy, mprf2exu_busy_vec, mprf2exu_pend_cnt
   );

endinterface : scr1_pipe_mprf_sb_if

// File: rtl/scr1_pipe_mprf_sb_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, clearing writeback resets,
// issue wins on collision; also gives the same-cycle busy view per read port.
module scr1_mprf_scoreboard
   import scr1_mprf_pkg::*;
#(
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1,
   parameter int unsigned AW     = 5,
   parameter int unsigned NREGS  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_req_i,
   input  logic [AW-1:0]        iss_addr_i,
   input  logic [NUM_WR-1:0]    w_req_i,
   input  logic [NUM_WR-1:0]    w_clr_i,
   input  logic [NUM_WR*AW-1:0] wr_addr_i,
   input  logic [NUM_RD*AW-1:0] rs_addr_i,
   output logic [NUM_RD-1:0]    rs_busy_o,
   output logic [NREGS-1:0]     busy_vec_o,
   output logic [AW:0]          pend_cnt_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] set_vec;
   logic [NREGS-1:0] clr_vec;
   logic [NREGS-1:0] rise_vec;
   logic [NREGS-1:0] fall_vec;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;

   // Decode issue and clearing writebacks into one-hot-per-register vectors; x0 never tracked.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
         set_vec[r] = iss_req_i && (iss_addr_i == AW'(r));
      end
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (w_req_i[p] && w_clr_i[p]) begin
            clr_vec[wr_addr_i[p*AW +: AW]] = 1'b1;
         end
      end
      clr_vec[0] = 1'b0;
   end

   always_comb begin
      busy_d    = set_vec | (busy_q & ~clr_vec);
      busy_d[0] = 1'b0;
      rise_vec  = busy_d & ~busy_q;
      fall_vec  = busy_q & ~busy_d;
      cnt_d     = cnt_q + (AW+1)'($countones(rise_vec)) - (AW+1)'($countones(fall_vec));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // The next-state bit is exactly the same-cycle view EXU needs alongside the data bypass.
   always_comb begin
      rs_busy_o = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (rs_addr_i[i*AW +: AW] != '0) begin
            rs_busy_o[i] = busy_d[rs_addr_i[i*AW +: AW]];
         end
      end
   end

   assign busy_vec_o = busy_q;
   assign pend_cnt_o = cnt_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (cnt_q == (AW+1)'($countones(busy_q)))
            else $error("scoreboard count %0d disagrees with busy vector %0h", cnt_q, busy_q);
      end
   end
`endif

endmodule : scr1_mprf_scoreboard

// File: rtl/scr1_pipe_mprf_sb.sv
// Multi-port register file with write-through bypass and pending-write scoreboard.
// Storage, write arbitration and the read bypass live here; busy tracking is delegated.
module scr1_pipe_mprf_sb
   import scr1_mprf_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned RVE    = 0,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1
) (
   input  logic                clk,
   input  logic                rst,
   scr1_pipe_mprf_sb_if.slave  mprf
);

   localparam int unsigned AW    = scr1_mprf_aw(RVE);
   localparam int unsigned NREGS = scr1_mprf_nregs(RVE);

   logic [XLEN-1:0] regs_q [1:NREGS-1];
   logic [XLEN-1:0] regs_d [1:NREGS-1];

   logic [AW-1:0]   wr_addr [NUM_WR];
   logic [XLEN-1:0] wr_data [NUM_WR];
   logic [AW-1:0]   rs_addr [NUM_RD];

   for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
      assign wr_addr[p] = mprf.exu2mprf_rd_addr[p*AW +: AW];
      assign wr_data[p] = mprf.exu2mprf_rd_data[p*XLEN +: XLEN];
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
      assign rs_addr[i] = mprf.exu2mprf_rs_addr[i*AW +: AW];
   end

   // Later ports overwrite earlier ones, so the highest-index writer wins per register.
   always_comb begin
      regs_d = regs_q;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         if (mprf.exu2mprf_w_req[p] && (wr_addr[p] != '0)) begin
            regs_d[wr_addr[p]] = wr_data[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 1; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 1; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   // Read with same-cycle bypass; x0 is hardwired to zero.
   always_comb begin
      mprf.mprf2exu_rs_data = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (rs_addr[i] != '0) begin
            mprf.mprf2exu_rs_data[i*XLEN +: XLEN] = regs_q[rs_addr[i]];
            for (int unsigned p = 0; p < NUM_WR; p++) begin
               if (mprf.exu2mprf_w_req[p] && (wr_addr[p] == rs_addr[i])) begin
                  mprf.mprf2exu_rs_data[i*XLEN +: XLEN] = wr_data[p];
               end
            end
         end
      end
   end

   scr1_mprf_scoreboard #(
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR),
      .AW     (AW),
      .NREGS  (NREGS)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .iss_req_i  (mprf.exu2mprf_iss_req),
      .iss_addr_i (mprf.exu2mprf_iss_addr),
      .w_req_i    (mprf.exu2mprf_w_req),
      .w_clr_i    (mprf.exu2mprf_w_clr),
      .wr_addr_i  (mprf.exu2mprf_rd_addr),
      .rs_addr_i  (mprf.exu2mprf_rs_addr),
      .rs_busy_o  (mprf.mprf2exu_rs_busy),
      .busy_vec_o (mprf.mprf2exu_busy_vec),
      .pend_cnt_o (mprf.mprf2exu_pend_cnt)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (mprf.exu2mprf_w_req[p]) begin
               assert (!$isunknown(wr_addr[p]) && !$isunknown(wr_data[p]))
                  else $error("write port %0d carries unknown address or data", p);
            end
         end
      end
   end
`endif

endmodule : scr1_pipe_mprf_sb
